db_req: RTL and testbench

DB_REQ -- requirements
Module: db_req

---
 rtl/db_req.sv | 187 ++++++++++++++++++
 tb/tb_db_req.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/db_req.sv
// Doorbell readiness query: sends one doorbell request beat to des_id, waits for
// the endpoint's reply, and retries with a back-off gap on failure or timeout.
module db_req #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 3,
  parameter int RETRY_GAP      = 64
) (
  input  logic        log_clk,
  input  logic        log_rst,
  input  logic [15:0] src_id,
  input  logic [15:0] des_id,
  input  logic        db_start,
  // request channel
  input  logic        ireq_tready_in,
  output logic        ireq_tvalid_o,
  output logic        ireq_tlast_o,
  output logic [63:0] ireq_tdata_o,
  output logic [7:0]  ireq_tkeep_o,
  output logic [31:0] ireq_tuser_o,
  // response channel
  input  logic        iresp_tvalid_in,
  input  logic        iresp_tlast_in,
  input  logic [63:0] iresp_tdata_in,
  input  logic [7:0]  iresp_tkeep_in,
  input  logic [31:0] iresp_tuser_in,
  output logic        iresp_tready_o,
  // status
  output logic        busy_o,
  output logic        done_o,
  output logic        ep_ready_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic [1:0]  state_dbg
);

  // Handshake: a beat transfers on a rising edge where valid and ready are both 1;
  // once valid is raised, the beat (data, keep, user, last) is held unchanged
  // until that transfer, and valid never drops before it.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT    = 2'd2,
    BACKOFF = 2'd3
  } state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;

  localparam logic [15:0] INFO_READY = 16'h0100;
  localparam logic [3:0]  FTYPE_DB   = 4'hA;

  state_t          state;
  logic [TW-1:0]   wait_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [RW-1:0]   retry_cnt;
  logic [7:0]      tid;
  logic            first_beat;

  logic            resp_hit;
  logic            resp_ok;
  logic            wait_last;
  logic            retry_left;
  logic [15:0]     resp_info;
  logic [63:0]     req_data;
  logic            unused_resp_bits;

  assign state_dbg = state;

  // Responses are always accepted; only reset holds the channel off.
  assign iresp_tready_o = ~log_rst;

  assign resp_info  = iresp_tdata_in[31:16];
  assign resp_hit   = (state == WAIT) && iresp_tvalid_in && first_beat &&
                      (iresp_tdata_in[55:52] == FTYPE_DB) &&
                      (iresp_tuser_in[31:16] == des_id);
  assign resp_ok    = resp_hit && (resp_info == INFO_READY);
  assign wait_last  = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign retry_left = (retry_cnt < RW'(MAX_RETRY));

  // Doorbell header: TID, ftype, fixed fields, info 16'h0001 (readiness query).
  assign req_data = {tid, FTYPE_DB, 7'b0000001, 1'b0, 12'h000, 16'h0001, 16'h0000};

  assign unused_resp_bits = ^{iresp_tkeep_in, iresp_tdata_in[63:56],
                              iresp_tdata_in[51:32], iresp_tdata_in[15:0],
                              iresp_tuser_in[15:0]};

  // Decoding is limited to the first beat of each response packet.
  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      first_beat <= 1'b1;
    end else if (iresp_tvalid_in) begin
      first_beat <= iresp_tlast_in;
    end
  end

  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      gap_cnt       <= '0;
      retry_cnt     <= '0;
      tid           <= 8'h00;
      ireq_tvalid_o <= 1'b0;
      ireq_tlast_o  <= 1'b0;
      ireq_tdata_o  <= '0;
      ireq_tkeep_o  <= '0;
      ireq_tuser_o  <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      ep_ready_o    <= 1'b0;
      fail_o        <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (db_start) begin
            state      <= SEND;
            busy_o     <= 1'b1;
            ep_ready_o <= 1'b0;
            fail_o     <= 1'b0;
            timeout_o  <= 1'b0;
            retry_cnt  <= '0;
          end
        end

        SEND: begin
          if (!ireq_tvalid_o) begin
            ireq_tvalid_o <= 1'b1;
            ireq_tlast_o  <= 1'b1;
            ireq_tdata_o  <= req_data;
            ireq_tkeep_o  <= 8'hFF;
            ireq_tuser_o  <= {src_id, des_id};
          end else if (ireq_tready_in) begin
            ireq_tvalid_o <= 1'b0;
            ireq_tlast_o  <= 1'b0;
            ireq_tdata_o  <= '0;
            ireq_tkeep_o  <= '0;
            ireq_tuser_o  <= '0;
            tid           <= tid + 8'h01;
            wait_cnt      <= '0;
            state         <= WAIT;
          end
        end

        WAIT: begin
          // A match on the final timeout cycle takes priority over the timeout.
          if (resp_ok) begin
            ep_ready_o <= 1'b1;
            done_o     <= 1'b1;
            busy_o     <= 1'b0;
            state      <= IDLE;
          end else if (resp_hit || wait_last) begin
            if (!resp_hit) begin
              timeout_o <= 1'b1;
            end
            if (retry_left) begin
              retry_cnt <= retry_cnt + 1'b1;
              gap_cnt   <= '0;
              state     <= BACKOFF;
            end else begin
              fail_o <= 1'b1;
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        BACKOFF: begin
          if (gap_cnt == GW'(RETRY_GAP - 1)) begin
            state <= SEND;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_db_req.sv
// Self-checking bench for db_req: a query-level timeline model predicts every
// status/request output each cycle; directed tests pin latencies and TIDs.
module tb_db_req;

  localparam int T   = 16;
  localparam int MR  = 3;
  localparam int GAP = 8;
  localparam logic [15:0] SRC = 16'h1234;
  localparam logic [15:0] DES = 16'h5678;

  logic        log_clk, log_rst;
  logic [15:0] src_id, des_id;
  logic        db_start;
  logic        ireq_tready_in, ireq_tvalid_o, ireq_tlast_o;
  logic [63:0] ireq_tdata_o;
  logic [7:0]  ireq_tkeep_o;
  logic [31:0] ireq_tuser_o;
  logic        iresp_tvalid_in, iresp_tlast_in;
  logic [63:0] iresp_tdata_in;
  logic [7:0]  iresp_tkeep_in;
  logic [31:0] iresp_tuser_in;
  logic        iresp_tready_o;
  logic        busy_o, done_o, ep_ready_o, fail_o, timeout_o;
  logic [1:0]  state_dbg;

  db_req #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MR), .RETRY_GAP(GAP)) u_dut (
    .log_clk(log_clk), .log_rst(log_rst), .src_id(src_id), .des_id(des_id),
    .db_start(db_start), .ireq_tready_in(ireq_tready_in),
    .ireq_tvalid_o(ireq_tvalid_o), .ireq_tlast_o(ireq_tlast_o),
    .ireq_tdata_o(ireq_tdata_o), .ireq_tkeep_o(ireq_tkeep_o),
    .ireq_tuser_o(ireq_tuser_o), .iresp_tvalid_in(iresp_tvalid_in),
    .iresp_tlast_in(iresp_tlast_in), .iresp_tdata_in(iresp_tdata_in),
    .iresp_tkeep_in(iresp_tkeep_in), .iresp_tuser_in(iresp_tuser_in),
    .iresp_tready_o(iresp_tready_o), .busy_o(busy_o), .done_o(done_o),
    .ep_ready_o(ep_ready_o), .fail_o(fail_o), .timeout_o(timeout_o),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    log_clk = 1'b0;
    forever #5 log_clk = ~log_clk;
  end
  always @(posedge log_clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] acc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] build_req(input logic [7:0] t);
    return {t, 4'hA, 7'b0000001, 1'b0, 12'h000, 16'h0001, 16'h0000};
  endfunction

  // ---------------- behavioural model ----------------
  logic       exp_busy = 0, exp_tvalid = 0, exp_done = 0;
  logic       exp_ep = 0, exp_fail = 0, exp_to = 0;
  logic [7:0] m_tid = 8'h00;
  logic       m_first;

  always @(posedge log_clk or posedge log_rst) begin
    if (log_rst) m_first <= 1'b1;
    else if (iresp_tvalid_in) m_first <= iresp_tlast_in;
  end

  task automatic tick(output bit ab);
    @(posedge log_clk);
    exp_done = 1'b0;
    ab = log_rst;
    if (log_rst) begin
      exp_busy = 0; exp_tvalid = 0; exp_ep = 0; exp_fail = 0; exp_to = 0;
      m_tid = 8'h00;
      exp_q.delete();
    end
  endtask

  initial begin : model
    bit ab;
    bit hit;
    int outcome;  // 1 ready, 2 refused, 3 timed out
    forever begin
      tick(ab);
      if (!ab && db_start) begin
        exp_busy = 1; exp_ep = 0; exp_fail = 0; exp_to = 0;
        for (int att = 0; att <= MR; att++) begin
          tick(ab);
          if (ab) break;
          exp_tvalid = 1;
          exp_q.push_back(build_req(m_tid));
          do tick(ab); while (!ab && !ireq_tready_in);
          if (ab) break;
          exp_tvalid = 0;
          m_tid = m_tid + 8'h01;
          outcome = 0;
          for (int c = 0; c < T; c++) begin
            tick(ab);
            if (ab) break;
            hit = iresp_tvalid_in && m_first && (iresp_tdata_in[55:52] == 4'hA) &&
                  (iresp_tuser_in[31:16] == DES);
            if (hit) begin
              outcome = (iresp_tdata_in[31:16] == 16'h0100) ? 1 : 2;
              break;
            end
            if (c == T - 1) outcome = 3;
          end
          if (ab) break;
          if (outcome == 3) exp_to = 1;
          if (outcome == 1) begin
            exp_ep = 1; exp_done = 1; exp_busy = 0;
            break;
          end
          if (att == MR) begin
            exp_fail = 1; exp_done = 1; exp_busy = 0;
            break;
          end
          for (int g = 0; g < GAP; g++) begin
            tick(ab);
            if (ab) break;
          end
          if (ab) break;
        end
      end
    end
  end

  // ---------------- compare process + monitor ----------------
  always @(negedge log_clk) begin
    chk("busy_o", busy_o, log_rst ? 1'b0 : exp_busy);
    chk("done_o", done_o, log_rst ? 1'b0 : exp_done);
    chk("ep_ready_o", ep_ready_o, log_rst ? 1'b0 : exp_ep);
    chk("fail_o", fail_o, log_rst ? 1'b0 : exp_fail);
    chk("timeout_o", timeout_o, log_rst ? 1'b0 : exp_to);
    chk("ireq_tvalid_o", ireq_tvalid_o, log_rst ? 1'b0 : exp_tvalid);
    chk("iresp_tready_o", iresp_tready_o, !log_rst);
    if (exp_tvalid && !log_rst) begin
      chk("ireq_tdata_o", ireq_tdata_o, build_req(m_tid));
      chk("ireq_tuser_o", ireq_tuser_o, {SRC, DES});
      chk("ireq_tkeep_o", ireq_tkeep_o, 8'hFF);
      chk("ireq_tlast_o", ireq_tlast_o, 1'b1);
    end
  end

  always @(negedge log_clk) begin
    if (!log_rst && ireq_tvalid_o && ireq_tready_in) begin
      acc_q.push_back(ireq_tdata_o);
      if (exp_q.size() == 0) chk("sb_unexpected_beat", 64'd1, 64'd0);
      else chk("sb_beat", ireq_tdata_o, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic goto_cyc(input int t);
    while (cyc < t) begin
      @(posedge log_clk);
      #2;
    end
  endtask

  task automatic do_reset();
    @(posedge log_clk); #2;
    log_rst = 1'b1; db_start = 1'b0; iresp_tvalid_in = 1'b0;
    repeat (2) @(posedge log_clk);
    #2 log_rst = 1'b0;
  endtask

  task automatic pulse_start(output int n);
    @(posedge log_clk); #2;
    db_start = 1'b1; n = cyc;
    @(posedge log_clk); #2;
    db_start = 1'b0;
  endtask

  task automatic send_resp(input int t, input logic [15:0] info, input logic [15:0] rsrc,
                           input logic [3:0] hdr, input logic last);
    goto_cyc(t);
    iresp_tvalid_in = 1'b1;
    iresp_tlast_in  = last;
    iresp_tdata_in  = {8'h00, hdr, 20'h00000, info, 16'h0000};
    iresp_tkeep_in  = 8'hFF;
    iresp_tuser_in  = {rsrc, SRC};
    @(posedge log_clk); #2;
    iresp_tvalid_in = 1'b0;
    iresp_tlast_in  = 1'b0;
  endtask

  task automatic wait_accept(input string name, output int c);
    bit found = 0;
    c = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge log_clk);
      if (ireq_tvalid_o && ireq_tready_in) begin
        found = 1; c = cyc;
      end
    end
    if (!found) chk({name, "_accept_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_valid(input string name, output int c);
    bit found = 0;
    c = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge log_clk);
      if (ireq_tvalid_o) begin
        found = 1; c = cyc;
      end
    end
    if (!found) chk({name, "_valid_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_done(input string name, output int c);
    bit found = 0;
    c = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge log_clk);
      if (done_o) begin
        found = 1; c = cyc;
      end
    end
    if (!found) chk({name, "_done_timeout"}, 64'd0, 64'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n, a, r, d, v;
    logic [63:0] beat, d0;
    log_rst = 1'b1; src_id = SRC; des_id = DES; db_start = 1'b0;
    ireq_tready_in = 1'b1; iresp_tvalid_in = 1'b0; iresp_tlast_in = 1'b0;
    iresp_tdata_in = '0; iresp_tkeep_in = '0; iresp_tuser_in = '0;
    repeat (3) @(posedge log_clk);
    #2 log_rst = 1'b0;
    @(negedge log_clk);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_tvalid", ireq_tvalid_o, 1'b0);
    chk("rst_iresp_tready", iresp_tready_o, 1'b1);

    // single query answered ready
    acc_q.delete();
    pulse_start(n);
    wait_accept("t1", a);
    chk("t1_start_to_valid", a - n, 2);
    send_resp(a + 3, 16'h0100, DES, 4'hA, 1'b1);
    wait_done("t1", d);
    chk("t1_resp_to_done", d - (a + 3), 1);
    chk("t1_ep_ready", ep_ready_o, 1'b1);
    chk("t1_fail", fail_o, 1'b0);
    chk("t1_req_count", acc_q.size(), 1);
    beat = acc_q[0];
    chk("t1_tid", beat[63:56], 8'h00);
    chk("t1_info", beat[31:16], 16'h0001);

    // endpoint always refuses: four attempts then fail
    do_reset(); acc_q.delete();
    pulse_start(n);
    for (int k = 0; k <= MR; k++) begin
      wait_accept("t2", a);
      if (k > 0) chk("t2_retry_gap", a - r, GAP + 2);
      r = a + 2;
      send_resp(r, 16'h01FF, DES, 4'hA, 1'b1);
    end
    wait_done("t2", d);
    chk("t2_fail", fail_o, 1'b1);
    chk("t2_ep_ready", ep_ready_o, 1'b0);
    chk("t2_timeout", timeout_o, 1'b0);
    chk("t2_req_count", acc_q.size(), 4);
    for (int k = 0; k < 4 && k < acc_q.size(); k++) begin
      beat = acc_q[k];
      chk("t2_tid", beat[63:56], k);
    end

    // no response at all: every attempt times out
    do_reset(); acc_q.delete();
    pulse_start(n);
    for (int k = 0; k <= MR; k++) wait_accept("t3", a);
    wait_done("t3", d);
    chk("t3_wait_to_done", d - (a + 1), T);
    chk("t3_timeout", timeout_o, 1'b1);
    chk("t3_fail", fail_o, 1'b1);

    // refused once (other info value), then ready on the retry
    do_reset(); acc_q.delete();
    pulse_start(n);
    wait_accept("t7", a);
    send_resp(a + 1, 16'h0055, DES, 4'hA, 1'b1);
    wait_accept("t7", v);
    chk("t7_retry_gap", v - (a + 1), GAP + 2);
    send_resp(v + 1, 16'h0100, DES, 4'hA, 1'b1);
    wait_done("t7", d);
    chk("t7_ep_ready", ep_ready_o, 1'b1);

    // back-pressure: request held stable, TID advances only on acceptance
    do_reset(); acc_q.delete();
    ireq_tready_in = 1'b0;
    pulse_start(n);
    wait_valid("t4", v);
    chk("t4_start_to_valid", v - n, 2);
    d0 = ireq_tdata_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge log_clk);
      chk("t4_hold_valid", ireq_tvalid_o, 1'b1);
      chk("t4_hold_data", ireq_tdata_o, d0);
    end
    chk("t4_no_accept", acc_q.size(), 0);
    @(posedge log_clk); #2 ireq_tready_in = 1'b1;
    wait_accept("t4", a);
    send_resp(a + 2, 16'h0100, DES, 4'hA, 1'b1);
    wait_done("t4", d);
    pulse_start(n);
    wait_accept("t4b", a);
    send_resp(a + 2, 16'h0100, DES, 4'hA, 1'b1);
    wait_done("t4b", d);
    chk("t4_req_count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      beat = acc_q[0]; chk("t4_tid0", beat[63:56], 8'h00);
      beat = acc_q[1]; chk("t4_tid1", beat[63:56], 8'h01);
    end

    // ignored beats (wrong source, non-first beat), then a valid reply
    do_reset();
    pulse_start(n);
    wait_accept("t5", a);
    send_resp(a + 2, 16'h0100, DES ^ 16'h0001, 4'hA, 1'b1);
    send_resp(a + 4, 16'h0100, DES, 4'h5, 1'b0);
    send_resp(a + 5, 16'h0100, DES, 4'hA, 1'b1);
    @(negedge log_clk);
    chk("t5_still_busy", busy_o, 1'b1);
    send_resp(a + 8, 16'h0100, DES, 4'hA, 1'b1);
    wait_done("t5", d);
    chk("t5_done_cycle", d - a, 9);
    chk("t5_ep_ready", ep_ready_o, 1'b1);
    // reply lands on the last WAIT cycle: match wins over timeout
    pulse_start(n);
    wait_accept("t5b", a);
    send_resp(a + T, 16'h0100, DES, 4'hA, 1'b1);
    wait_done("t5b", d);
    chk("t5b_done_cycle", d - a, T + 1);
    chk("t5b_ep_ready", ep_ready_o, 1'b1);
    chk("t5b_timeout", timeout_o, 1'b0);

    // reset mid-query in WAIT, then in SEND under back-pressure
    pulse_start(n);
    wait_accept("t6", a);
    goto_cyc(a + 5);
    log_rst = 1'b1;
    #1;
    chk("t6_wait_rst_busy", busy_o, 1'b0);
    chk("t6_wait_rst_ep", ep_ready_o, 1'b0);
    chk("t6_wait_rst_tvalid", ireq_tvalid_o, 1'b0);
    repeat (2) @(posedge log_clk);
    #2 log_rst = 1'b0;
    acc_q.delete();
    pulse_start(n);
    wait_accept("t6b", a);
    send_resp(a + 2, 16'h0100, DES, 4'hA, 1'b1);
    wait_done("t6b", d);
    chk("t6b_ep_ready", ep_ready_o, 1'b1);
    beat = (acc_q.size() > 0) ? acc_q[0] : 64'hFFFF_FFFF_FFFF_FFFF;
    chk("t6b_tid_after_rst", beat[63:56], 8'h00);
    ireq_tready_in = 1'b0;
    pulse_start(n);
    wait_valid("t6c", v);
    @(posedge log_clk); #2 log_rst = 1'b1;
    #1;
    chk("t6c_send_rst_tvalid", ireq_tvalid_o, 1'b0);
    chk("t6c_send_rst_busy", busy_o, 1'b0);
    repeat (2) @(posedge log_clk);
    #2 log_rst = 1'b0;
    ireq_tready_in = 1'b1;
    repeat (3) @(negedge log_clk);
    pulse_start(n);
    wait_accept("t6d", a);
    chk("t6d_start_to_valid", a - n, 2);
    send_resp(a + 2, 16'h0100, DES, 4'hA, 1'b1);
    wait_done("t6d", d);
    chk("t6d_ep_ready", ep_ready_o, 1'b1);

    repeat (3) @(negedge log_clk);
    chk("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
